cache_reconfig_ctrl: RTL and testbench
======================================

// Module: cache_reconfig_ctrl
// PURPOSE
//  Sequences run-time reconfiguration of the reconfigurable cache top. Sits between the requester
//  and the cache request port, gating new requests. On a mode-change command it drains in-flight
//  requests, flushes the cache, then drives the new 2-bit reconfiguration value and resumes traffic.
// PARAMETERS
//  MSG_W           76  cache request message width {type[2],opaque[8],addr[32],len[2],data[32]}
//  MODE_W          2   reconfiguration mode width
//  MAX_OUTSTANDING 4   maximum accepted-but-unanswered requests (1..2^CNT_W-1)
//  CNT_W           3   outstanding-counter width
//  SETTLE_CYCLES   2   idle cycles after a mode update before traffic resumes (>=1)
//  RESET_MODE      0   reconfiguration value driven out of reset
// PORTS
//  clk              in   1       clock
//  reset            in   1       asynchronous reset, active high
//  cfg_req_val      in   1       mode-change command valid
//  cfg_req_mode     in   MODE_W  requested mode
//  cfg_req_rdy      out  1       command accepted when val&rdy
//  cfg_done         out  1       one-cycle pulse: command completed
//  in_req_val       in   1       requester cache request valid
//  in_req_rdy       out  1       requester cache request ready
//  in_req_msg       in   MSG_W   requester cache request message
//  cachereq_val     out  1       to cache: request valid
//  cachereq_rdy     in   1       from cache: request ready
//  cachereq_msg     out  MSG_W   to cache: equals in_req_msg (combinational)
//  cacheresp_val    in   1       cache response valid (monitored only)
//  cacheresp_rdy    in   1       requester response ready (monitored only)
//  flush_req        out  1       to cache: flush request, held until flush_done
//  flush_done       in   1       from cache: flush complete
//  reconfiguration  out  MODE_W  registered mode to the cache
//  busy             out  1       high in any state other than RUN
//  err_underflow    out  1       sticky: response fire seen with outstanding==0
// BEHAVIOUR
//  Reset (async): state=RUN, reconfiguration=RESET_MODE, outstanding=0, pending=0, settle count=0,
//   flush_req=0, cfg_done=0, err_underflow=0.
//  req_fire = cachereq_val&cachereq_rdy; resp_fire = cacheresp_val&cacheresp_rdy.
//  outstanding: +1 on req_fire only, -1 on resp_fire only, unchanged on both/neither.
//   resp_fire at 0: stays 0 and sets err_underflow (cleared only by reset).
//  Gating (combinational): open = (state==RUN) && (outstanding<MAX_OUTSTANDING).
//   cachereq_val = in_req_val&open; in_req_rdy = cachereq_rdy&open.
//  FSM:
//   RUN: cfg_req_rdy=1. On cfg fire with cfg_req_mode==reconfiguration, pulse cfg_done next cycle
//    and stay in RUN (no flush). Otherwise latch pending=cfg_req_mode and go to DRAIN. A request
//    firing in the same cycle is accepted and counted.
//   DRAIN: cfg_req_rdy=0 and requests blocked. Go to FLUSH when outstanding==0 (checked in-state).
//   FLUSH: flush_req=1 (registered; rises on the cycle FLUSH is entered). When flush_done is
//    sampled high: flush_req<=0 and go to APPLY. flush_done outside FLUSH is ignored.
//   APPLY: reconfiguration<=pending; settle count<=SETTLE_CYCLES-1; go to SETTLE.
//   SETTLE: decrement each cycle; at 0 go to RUN and pulse cfg_done for exactly one cycle.
//  Latency, mode change with no traffic: cfg fire at cycle T -> DRAIN T+1, FLUSH T+2,
//   flush_req high T+2. With flush_done at F: reconfiguration updates at F+2; RUN and
//   cfg_done at F+2+SETTLE_CYCLES.
//  cfg_req_mode is sampled only at fire. Responses keep decrementing in every state.
//  Reset mid-sequence aborts it immediately: mode returns to RESET_MODE, flush_req drops, and
//   the pending command is lost.
// TESTING
//  T1 reset: assert reset mid-cycle -> all outputs at reset values immediately;
//   reconfiguration=0, in_req_rdy follows cachereq_rdy.
//  T2 idle change: cfg mode=1, no traffic, flush_done 3 cycles after flush_req ->
//   reconfiguration=1 and cfg_done timing exactly as in the latency rule; busy low afterwards.
//  T3 drain: write addr 0x100 data 0x0e0f0102 accepted, then cfg mode=2 -> flush_req stays low
//   until the response fires; new requests are blocked (in_req_rdy=0) throughout.
//  T4 same mode: cfg mode equal to current -> cfg_done pulse 1 cycle later; flush_req never rises.
//  T5 counter: issue 4 requests with no responses -> 5th blocked; simultaneous req/resp fire
//   keeps count 4; a response with count 0 sets err_underflow.
//  T6 abort: reset asserted while in FLUSH -> flush_req=0 and reconfiguration=RESET_MODE;
//   a later command completes normally.

Source files
------------

// File: rtl/cache_reconfig_ctrl.sv
// cache_reconfig_ctrl: gates cache requests and sequences drain -> flush -> mode apply -> settle
// whenever a mode-change command asks for a value different from the one currently driven.
module cache_reconfig_ctrl #(
    parameter int MSG_W           = 76,
    parameter int MODE_W          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3,
    parameter int SETTLE_CYCLES   = 2,
    parameter int RESET_MODE      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_req_val,
    input  logic [MODE_W-1:0] cfg_req_mode,
    output logic              cfg_req_rdy,
    output logic              cfg_done,
    input  logic              in_req_val,
    output logic              in_req_rdy,
    input  logic [MSG_W-1:0]  in_req_msg,
    output logic              cachereq_val,
    input  logic              cachereq_rdy,
    output logic [MSG_W-1:0]  cachereq_msg,
    input  logic              cacheresp_val,
    input  logic              cacheresp_rdy,
    output logic              flush_req,
    input  logic              flush_done,
    output logic [MODE_W-1:0] reconfiguration,
    output logic              busy,
    output logic              err_underflow
);
    localparam int                SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  MAX_O    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [MODE_W-1:0] RST_M    = MODE_W'(RESET_MODE);
    localparam logic [SET_W-1:0]  SET_INIT = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {RUN, DRAIN, FLUSH, APPLY, SETTLE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_outstanding;
    logic [MODE_W-1:0] r_pending, r_mode;
    logic [SET_W-1:0]  r_settle;
    logic              r_flush, r_done, r_err;
    logic              w_open, w_req_fire, w_resp_fire, w_cfg_fire, w_same;

    assign w_open          = (r_state == RUN) && (r_outstanding < MAX_O);
    assign cachereq_val    = in_req_val & w_open;
    assign in_req_rdy      = cachereq_rdy & w_open;
    assign cachereq_msg    = in_req_msg;
    assign w_req_fire      = cachereq_val & cachereq_rdy;
    assign w_resp_fire     = cacheresp_val & cacheresp_rdy;
    assign cfg_req_rdy     = r_state == RUN;
    assign w_cfg_fire      = cfg_req_val & cfg_req_rdy;
    assign w_same          = cfg_req_mode == r_mode;
    assign cfg_done        = r_done;
    assign flush_req       = r_flush;
    assign reconfiguration = r_mode;
    assign busy            = r_state != RUN;
    assign err_underflow   = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     w_state_nxt = (w_cfg_fire && !w_same) ? DRAIN : RUN;
            DRAIN:   w_state_nxt = (r_outstanding == '0) ? FLUSH : DRAIN;
            FLUSH:   w_state_nxt = flush_done ? APPLY : FLUSH;
            APPLY:   w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = (r_settle == '0) ? RUN : SETTLE;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_outstanding <= '0;
            r_pending     <= '0;
            r_mode        <= RST_M;
            r_settle      <= '0;
            r_flush       <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // flush_req is high for exactly the cycles spent in FLUSH
            r_flush <= w_state_nxt == FLUSH;
            r_done  <= (w_cfg_fire && w_same) || (r_state == SETTLE && r_settle == '0);
            if (w_cfg_fire && !w_same)
                r_pending <= cfg_req_mode;
            if (r_state == APPLY) begin
                r_mode   <= r_pending;
                r_settle <= SET_INIT;
            end else if (r_state == SETTLE && r_settle != '0) begin
                r_settle <= r_settle - 1'b1;
            end
            if (w_req_fire && !w_resp_fire)
                r_outstanding <= r_outstanding + 1'b1;
            else if (w_resp_fire && !w_req_fire && r_outstanding != '0)
                r_outstanding <= r_outstanding - 1'b1;
            if (w_resp_fire && r_outstanding == '0)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_reconfig_ctrl.sv
// tb_cache_reconfig_ctrl: directed stimulus with a timestamp-based reference model compared
// every cycle, plus literal expectations for the latency, drain, counter and abort scenarios.
module tb_cache_reconfig_ctrl;
    localparam int SETTLE = 2;
    localparam int MAXO   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_req_val = 1'b0;
    logic [1:0]  cfg_req_mode = 2'd0;
    logic        cfg_req_rdy, cfg_done;
    logic        in_req_val = 1'b0;
    logic        in_req_rdy;
    logic [75:0] in_req_msg = '0;
    logic        cachereq_val;
    logic        cachereq_rdy = 1'b1;
    logic [75:0] cachereq_msg;
    logic        cacheresp_val = 1'b0;
    logic        cacheresp_rdy = 1'b0;
    logic        flush_req;
    logic        flush_done = 1'b0;
    logic [1:0]  reconfiguration;
    logic        busy, err_underflow;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    cache_reconfig_ctrl #(.SETTLE_CYCLES(SETTLE), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset),
        .cfg_req_val(cfg_req_val), .cfg_req_mode(cfg_req_mode), .cfg_req_rdy(cfg_req_rdy),
        .cfg_done(cfg_done),
        .in_req_val(in_req_val), .in_req_rdy(in_req_rdy), .in_req_msg(in_req_msg),
        .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy), .cachereq_msg(cachereq_msg),
        .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .flush_req(flush_req), .flush_done(flush_done),
        .reconfiguration(reconfiguration), .busy(busy), .err_underflow(err_underflow)
    );

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a command is either idle, draining, flushing, or waiting for the
    // timestamps the latency rule derives from the cycle flush_done was sampled.
    typedef struct {
        int         out;
        logic [1:0] mode;
        logic [1:0] pend;
        bit         err, done, drain, flush, waiting;
        int         cyc, mode_at, run_at;
    } model_t;

    model_t m;

    function automatic model_t model_init();
        model_t n;
        n.out = 0; n.mode = 2'd0; n.pend = 2'd0;
        n.err = 0; n.done = 0; n.drain = 0; n.flush = 0; n.waiting = 0;
        n.cyc = 0; n.mode_at = -1; n.run_at = -1;
        return n;
    endfunction

    function automatic model_t model_step(model_t s);
        model_t n = s;
        bit blk  = s.drain | s.flush | s.waiting;
        bit open = !blk && s.out < MAXO;
        bit rf   = in_req_val && open && cachereq_rdy;
        bit rsp  = cacheresp_val && cacheresp_rdy;
        n.done = 0;
        if (s.flush && flush_done) begin
            n.flush = 0; n.waiting = 1;
            n.mode_at = s.cyc + 2; n.run_at = s.cyc + 2 + SETTLE;
        end
        if (s.drain && s.out == 0) begin
            n.drain = 0; n.flush = 1;
        end
        if (!blk && cfg_req_val) begin
            if (cfg_req_mode == s.mode) n.done = 1;
            else begin n.drain = 1; n.pend = cfg_req_mode; end
        end
        if (rsp && s.out == 0) n.err = 1;
        if (rf && !rsp) n.out = s.out + 1;
        else if (rsp && !rf && s.out > 0) n.out = s.out - 1;
        n.cyc = s.cyc + 1;
        if (n.cyc == s.mode_at) n.mode = s.pend;
        if (n.cyc == s.run_at) begin n.waiting = 0; n.done = 1; end
        return n;
    endfunction

    always @(posedge clk or posedge reset)
        m <= reset ? model_init() : model_step(m);

    always @(negedge clk) begin
        if (!reset) begin
            bit eb, eo;
            eb = m.drain | m.flush | m.waiting;
            eo = !eb && m.out < MAXO;
            chk("m_cfg_req_rdy", cfg_req_rdy, !eb);
            chk("m_cfg_done", cfg_done, m.done);
            chk("m_flush_req", flush_req, m.flush);
            chk("m_reconfiguration", reconfiguration, m.mode);
            chk("m_busy", busy, eb);
            chk("m_err_underflow", err_underflow, m.err);
            chk("m_cachereq_val", cachereq_val, in_req_val & eo);
            chk("m_in_req_rdy", in_req_rdy, cachereq_rdy & eo);
            chk("m_cachereq_msg", cachereq_msg, in_req_msg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flush(input string name);
        @(negedge clk);
        for (int i = 0; i < 20 && !flush_req; i++) @(negedge clk);
        chk(name, flush_req, 1'b1);
    endtask

    task automatic wait_done(input string name);
        @(negedge clk);
        for (int i = 0; i < 20 && !cfg_done; i++) @(negedge clk);
        chk(name, cfg_done, 1'b1);
    endtask

    task automatic pulse_flush_done();
        @(posedge clk);
        #1 flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [75:0] wr_msg;
        wr_msg = {2'd1, 8'h00, 32'h0000_0100, 2'd0, 32'h0e0f_0102};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mode", reconfiguration, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_req_rdy", in_req_rdy, 1'b1);
        chk("rst_cfg_req_rdy", cfg_req_rdy, 1'b1);

        // T2: idle mode change, flush_done three cycles after flush_req rises
        @(posedge clk);
        #1 cfg_req_val = 1'b1; cfg_req_mode = 2'd1;
        tick();
        cfg_req_val = 1'b0;
        @(negedge clk);
        chk("t2_busy_t1", busy, 1'b1);
        chk("t2_flush_t1", flush_req, 1'b0);
        tick();
        @(negedge clk);
        chk("t2_flush_t2", flush_req, 1'b1);
        repeat (3) tick();
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
        @(negedge clk);
        chk("t2_mode_f1", reconfiguration, 2'd0);
        chk("t2_flush_f1", flush_req, 1'b0);
        tick();
        @(negedge clk);
        chk("t2_mode_f2", reconfiguration, 2'd1);
        chk("t2_done_f2", cfg_done, 1'b0);
        tick();
        @(negedge clk);
        chk("t2_done_f3", cfg_done, 1'b0);
        chk("t2_busy_f3", busy, 1'b1);
        tick();
        @(negedge clk);
        chk("t2_done_f4", cfg_done, 1'b1);
        chk("t2_busy_f4", busy, 1'b0);
        tick();
        @(negedge clk);
        chk("t2_done_f5", cfg_done, 1'b0);

        // T3: one write in flight blocks the flush until its response
        @(posedge clk);
        #1 in_req_msg = wr_msg; in_req_val = 1'b1;
        tick();
        in_req_val = 1'b0; cfg_req_val = 1'b1; cfg_req_mode = 2'd2;
        tick();
        cfg_req_val = 1'b0; in_req_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_blocked", in_req_rdy, 1'b0);
            chk("t3_no_flush", flush_req, 1'b0);
        end
        @(posedge clk);
        #1 cacheresp_val = 1'b1; cacheresp_rdy = 1'b1;
        tick();
        cacheresp_val = 1'b0; in_req_val = 1'b0;
        wait_flush("t3_flush_rise");
        pulse_flush_done();
        wait_done("t3_done");
        chk("t3_mode", reconfiguration, 2'd2);

        // T4: same-mode command completes without a flush
        @(posedge clk);
        #1 cfg_req_val = 1'b1; cfg_req_mode = 2'd2;
        tick();
        cfg_req_val = 1'b0;
        @(negedge clk);
        chk("t4_done", cfg_done, 1'b1);
        chk("t4_no_flush", flush_req, 1'b0);
        tick();
        @(negedge clk);
        chk("t4_done_gone", cfg_done, 1'b0);

        // T5: outstanding limit, simultaneous fire, underflow
        @(posedge clk);
        #1 in_req_val = 1'b1;
        repeat (3) tick();
        cacheresp_val = 1'b1; cacheresp_rdy = 1'b1;
        tick();
        cacheresp_val = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_fifth_blocked", in_req_rdy, 1'b0);
        chk("t5_fifth_val", cachereq_val, 1'b0);
        @(posedge clk);
        #1 in_req_val = 1'b0; cacheresp_val = 1'b1;
        repeat (5) tick();
        cacheresp_val = 1'b0; cacheresp_rdy = 1'b0;
        @(negedge clk);
        chk("t5_underflow", err_underflow, 1'b1);

        // T1: asynchronous reset mid-cycle
        #1 reset = 1'b1;
        #1;
        chk("t1_err_clr", err_underflow, 1'b0);
        chk("t1_mode", reconfiguration, 2'd0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_done", cfg_done, 1'b0);
        chk("t1_rdy_hi", in_req_rdy, 1'b1);
        cachereq_rdy = 1'b0;
        #1 chk("t1_rdy_lo", in_req_rdy, 1'b0);
        cachereq_rdy = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        // T6: reset while flushing aborts, next command runs normally
        @(posedge clk);
        #1 cfg_req_val = 1'b1; cfg_req_mode = 2'd3;
        tick();
        cfg_req_val = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_in_flush", flush_req, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t6_flush_drop", flush_req, 1'b0);
        chk("t6_mode_reset", reconfiguration, 2'd0);
        chk("t6_busy", busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 cfg_req_val = 1'b1; cfg_req_mode = 2'd1;
        tick();
        cfg_req_val = 1'b0;
        wait_flush("t6_flush_rise");
        pulse_flush_done();
        wait_done("t6_done");
        chk("t6_mode", reconfiguration, 2'd1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
